// File: rtl/alu_issue_queue.sv
// alu_issue_queue: FIFO-buffered instruction feeder for the fixed-point ALU.
// Accepts host requests over valid/ready and issues one entry per cycle to the ALU.
// Two sequencing rules apply: a one-cycle bubble after each multiply-accumulate,
// and back-to-back delivery of MAT_LEN matrix-transpose rows.
//
// Ports:
//   i_clk, i_rst_n            clock (rising edge), async active-low reset
//   i_req_valid/o_req_ready   host handshake; ready is high while count < DEPTH
//   i_req_inst/a/b            host opcode and operands
//   i_alu_busy                ALU busy flag
//   o_alu_valid/inst/a/b      registered issue strobe and payload
//   o_count                   FIFO occupancy
//   o_group_active            high while a transpose group is issuing or draining
module alu_issue_queue #(
    parameter int unsigned       INST_W   = 4,
    parameter int unsigned       DATA_W   = 16,
    parameter int unsigned       DEPTH    = 16,
    parameter int unsigned       AW       = 4,
    parameter logic [INST_W-1:0] MAC_INST = 4'b0010,
    parameter logic [INST_W-1:0] MAT_INST = 4'b1001,
    parameter int unsigned       MAT_LEN  = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [INST_W-1:0] i_req_inst,
    input  logic [DATA_W-1:0] i_req_a,
    input  logic [DATA_W-1:0] i_req_b,
    input  logic              i_alu_busy,
    output logic              o_alu_valid,
    output logic [INST_W-1:0] o_alu_inst,
    output logic [DATA_W-1:0] o_alu_a,
    output logic [DATA_W-1:0] o_alu_b,
    output logic [AW:0]       o_count,
    output logic              o_group_active
);

    localparam int unsigned ROW_W     = (MAT_LEN > 1) ? $clog2(MAT_LEN) : 1;
    localparam int unsigned GUARD_MAX = 2 * MAT_LEN + 4;
    localparam int unsigned GUARD_W   = $clog2(GUARD_MAX + 1);

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } entry_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GAP   = 2'd1,
        S_GROUP = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    entry_t               mem [DEPTH];
    logic [AW-1:0]        wr_ptr_q;
    logic [AW-1:0]        rd_ptr_q;
    logic [AW:0]          count_q;
    state_t               state_q, state_d;
    logic [ROW_W-1:0]     row_q, row_d;
    logic                 seen_busy_q, seen_busy_d;
    logic [GUARD_W-1:0]   guard_q, guard_d;
    logic                 push_c;
    logic                 pop_c;
    logic                 has_entry_c;
    entry_t               head_c;
    entry_t               req_c;

    assign o_req_ready = (count_q < (AW+1)'(DEPTH));
    assign push_c      = i_req_valid && o_req_ready;
    assign has_entry_c = (count_q != '0);
    assign head_c      = mem[rd_ptr_q];
    assign req_c       = '{inst: i_req_inst, a: i_req_a, b: i_req_b};
    assign o_count     = count_q;

    // Entry storage; no reset needed, occupancy is tracked by the pointers.
    always_ff @(posedge i_clk) begin
        if (push_c) begin
            mem[wr_ptr_q] <= req_c;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_c) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push_c, pop_c})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            row_q       <= '0;
            seen_busy_q <= 1'b0;
            guard_q     <= '0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            seen_busy_q <= seen_busy_d;
            guard_q     <= guard_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        seen_busy_d = seen_busy_q;
        guard_d     = guard_q;
        case (state_q)
            S_IDLE: begin
                if (has_entry_c && !i_alu_busy) begin
                    if (head_c.inst == MAT_INST) begin
                        // A group starts only once every row is already queued.
                        if (count_q >= (AW+1)'(MAT_LEN)) begin
                            state_d = S_GROUP;
                            row_d   = '0;
                        end
                    end else if (head_c.inst == MAC_INST) begin
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                state_d = S_IDLE;
            end
            S_GROUP: begin
                row_d = row_q + ROW_W'(1);
                if (row_q == ROW_W'(MAT_LEN - 1)) begin
                    state_d     = S_DRAIN;
                    seen_busy_d = 1'b0;
                    guard_d     = '0;
                end
            end
            S_DRAIN: begin
                guard_d = guard_q + GUARD_W'(1);
                if (i_alu_busy) begin
                    seen_busy_d = 1'b1;
                end
                if (seen_busy_q && !i_alu_busy) begin
                    state_d = S_IDLE;
                end else if (!seen_busy_q && !i_alu_busy &&
                             guard_q >= GUARD_W'(GUARD_MAX - 1)) begin
                    // ALU never reported busy; do not stall forever.
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM output logic: pop decision.
    always_comb begin
        pop_c = 1'b0;
        case (state_q)
            S_IDLE:  pop_c = has_entry_c && !i_alu_busy && (head_c.inst != MAT_INST);
            S_GROUP: pop_c = has_entry_c;
            default: pop_c = 1'b0;
        endcase
    end

    // Registered issue port; payload holds its last value between issues.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_alu_valid    <= 1'b0;
            o_alu_inst     <= '0;
            o_alu_a        <= '0;
            o_alu_b        <= '0;
            o_group_active <= 1'b0;
        end else begin
            o_alu_valid    <= pop_c;
            o_group_active <= (state_d == S_GROUP) || (state_d == S_DRAIN);
            if (pop_c) begin
                o_alu_inst <= head_c.inst;
                o_alu_a    <= head_c.a;
                o_alu_b    <= head_c.b;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_queue.sv
// tb_alu_issue_queue: directed self-checking bench for alu_issue_queue.
module tb_alu_issue_queue;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_req_valid;
    logic        o_req_ready;
    logic [3:0]  i_req_inst;
    logic [15:0] i_req_a;
    logic [15:0] i_req_b;
    logic        i_alu_busy;
    logic        o_alu_valid;
    logic [3:0]  o_alu_inst;
    logic [15:0] o_alu_a;
    logic [15:0] o_alu_b;
    logic [4:0]  o_count;
    logic        o_group_active;

    int checks;
    int failures;

    alu_issue_queue dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_req_valid    (i_req_valid),
        .o_req_ready    (o_req_ready),
        .i_req_inst     (i_req_inst),
        .i_req_a        (i_req_a),
        .i_req_b        (i_req_b),
        .i_alu_busy     (i_alu_busy),
        .o_alu_valid    (o_alu_valid),
        .o_alu_inst     (o_alu_inst),
        .o_alu_a        (o_alu_a),
        .o_alu_b        (o_alu_b),
        .o_count        (o_count),
        .o_group_active (o_group_active)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic push(input logic [3:0] inst, input logic [15:0] a, input logic [15:0] b);
        i_req_valid = 1'b1;
        i_req_inst  = inst;
        i_req_a     = a;
        i_req_b     = b;
        tick();
        i_req_valid = 1'b0;
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        i_rst_n     = 1'b0;
        i_req_valid = 1'b0;
        i_req_inst  = '0;
        i_req_a     = '0;
        i_req_b     = '0;
        i_alu_busy  = 1'b0;
        repeat (3) tick();

        check("rst_valid", 32'(o_alu_valid), 32'd0);
        check("rst_count", 32'(o_count), 32'd0);
        check("rst_ready", 32'(o_req_ready), 32'd1);
        check("rst_group", 32'(o_group_active), 32'd0);
        check("rst_a", 32'(o_alu_a), 32'd0);
        i_rst_n = 1'b1;
        tick();

        // 1: single ADD, one-cycle latency
        push(4'h0, 16'h0400, 16'h0800);
        check("t1_nopop_yet", 32'(o_alu_valid), 32'd0);
        check("t1_count1", 32'(o_count), 32'd1);
        tick();
        check("t1_valid", 32'(o_alu_valid), 32'd1);
        check("t1_inst", 32'(o_alu_inst), 32'h0);
        check("t1_a", 32'(o_alu_a), 32'h0400);
        check("t1_b", 32'(o_alu_b), 32'h0800);
        check("t1_count0", 32'(o_count), 32'd0);
        tick();
        check("t1_pulse", 32'(o_alu_valid), 32'd0);
        check("t1_hold_a", 32'(o_alu_a), 32'h0400);

        // 2: MAC then SUB, bubble after MAC
        push(4'h2, 16'h0011, 16'h0022);
        push(4'h1, 16'h0033, 16'h0044);
        check("t2_mac_valid", 32'(o_alu_valid), 32'd1);
        check("t2_mac_inst", 32'(o_alu_inst), 32'h2);
        tick();
        check("t2_gap", 32'(o_alu_valid), 32'd0);
        tick();
        check("t2_sub_valid", 32'(o_alu_valid), 32'd1);
        check("t2_sub_inst", 32'(o_alu_inst), 32'h1);
        check("t2_sub_a", 32'(o_alu_a), 32'h0033);

        // 3: five ADDs held by busy, then drained in order
        i_alu_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push(4'h0, 16'h0100 + 16'(i), 16'h0);
            check("t3_busy_hold", 32'(o_alu_valid), 32'd0);
        end
        tick();
        check("t3_count5", 32'(o_count), 32'd5);
        i_alu_busy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t3_valid", 32'(o_alu_valid), 32'd1);
            check("t3_a", 32'(o_alu_a), 32'h0100 + 32'(i));
            check("t3_count", 32'(o_count), 32'(4 - i));
        end
        tick();
        check("t3_done", 32'(o_alu_valid), 32'd0);

        // 4: transpose group
        for (int i = 0; i < 7; i++) begin
            push(4'h9, 16'h0200 + 16'(i), 16'h0);
            check("t4_wait", 32'(o_alu_valid), 32'd0);
        end
        check("t4_grp_low", 32'(o_group_active), 32'd0);
        check("t4_count7", 32'(o_count), 32'd7);
        push(4'h9, 16'h0207, 16'h0);
        check("t4_count8", 32'(o_count), 32'd8);
        push(4'h0, 16'hAAAA, 16'h5555);
        check("t4_grp_high", 32'(o_group_active), 32'd1);
        check("t4_no_issue", 32'(o_alu_valid), 32'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("t4_row_valid", 32'(o_alu_valid), 32'd1);
            check("t4_row_a", 32'(o_alu_a), 32'h0200 + 32'(i));
            if (i == 0) i_alu_busy = 1'b1;
        end
        check("t4_count1", 32'(o_count), 32'd1);
        tick();
        check("t4_drain_noissue", 32'(o_alu_valid), 32'd0);
        check("t4_drain_grp", 32'(o_group_active), 32'd1);
        i_alu_busy = 1'b0;
        tick();
        check("t4_drain_exit", 32'(o_group_active), 32'd0);
        check("t4_exit_noissue", 32'(o_alu_valid), 32'd0);
        tick();
        check("t4_add_valid", 32'(o_alu_valid), 32'd1);
        check("t4_add_a", 32'(o_alu_a), 32'hAAAA);
        check("t4_add_b", 32'(o_alu_b), 32'h5555);

        // 5: full queue, held request, wrap-around order
        i_alu_busy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            push(4'h0, 16'h0500 + 16'(i), 16'h0);
        end
        check("t5_count16", 32'(o_count), 32'd16);
        check("t5_not_ready", 32'(o_req_ready), 32'd0);
        i_req_valid = 1'b1;
        i_req_inst  = 4'h0;
        i_req_a     = 16'h05FF;
        i_req_b     = 16'h0;
        tick();
        check("t5_held", 32'(o_count), 32'd16);
        i_alu_busy = 1'b0;
        tick();
        check("t5_pop0", 32'(o_alu_a), 32'h0500);
        check("t5_count15", 32'(o_count), 32'd15);
        check("t5_ready", 32'(o_req_ready), 32'd1);
        tick();
        i_req_valid = 1'b0;
        check("t5_accept_count", 32'(o_count), 32'd15);
        check("t5_pop1", 32'(o_alu_a), 32'h0501);
        for (int i = 2; i < 16; i++) begin
            tick();
            check("t5_order", 32'(o_alu_a), 32'h0500 + 32'(i));
        end
        tick();
        check("t5_last_valid", 32'(o_alu_valid), 32'd1);
        check("t5_last", 32'(o_alu_a), 32'h05FF);
        check("t5_empty", 32'(o_count), 32'd0);

        // 6: reset in the middle of a group
        for (int i = 0; i < 8; i++) begin
            push(4'h9, 16'h0300 + 16'(i), 16'h0);
        end
        tick();
        check("t6_grp", 32'(o_group_active), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t6_row_a", 32'(o_alu_a), 32'h0300 + 32'(i));
        end
        i_rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 32'(o_alu_valid), 32'd0);
        check("t6_rst_count", 32'(o_count), 32'd0);
        check("t6_rst_grp", 32'(o_group_active), 32'd0);
        check("t6_rst_ready", 32'(o_req_ready), 32'd1);
        tick();
        i_rst_n = 1'b1;
        tick();
        check("t6_idle", 32'(o_alu_valid), 32'd0);
        push(4'h0, 16'h0777, 16'h0888);
        tick();
        check("t6_add_valid", 32'(o_alu_valid), 32'd1);
        check("t6_add_a", 32'(o_alu_a), 32'h0777);
        check("t6_add_count", 32'(o_count), 32'd0);
        tick();
        check("t6_no_stale", 32'(o_alu_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_issue_queue.md
Name: alu_issue_queue

Overview:
Upstream feeder for the fixed-point ALU stage. It accepts instructions with their operands from the host over a valid/ready handshake and buffers them in a DEPTH-entry FIFO. It issues them to the ALU one per cycle while respecting the ALU busy flag. It enforces two ALU sequencing rules: one bubble after every multiply-accumulate, and back-to-back delivery of the 8 rows of a matrix-transpose group.

Parameters:
INST_W, 4, instruction width
DATA_W, 16, operand width (Q6.10)
DEPTH, 16, FIFO entries (power of 2)
AW, 4, log2(DEPTH)
MAC_INST, 4'b0010, multiply-accumulate opcode
MAT_INST, 4'b1001, matrix-transpose opcode
MAT_LEN, 8, rows per transpose group

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous, active-low reset
i_req_valid  in  1  host request valid
o_req_ready  out  1  queue can accept; high when count < DEPTH
i_req_inst  in  INST_W  host opcode
i_req_a  in  DATA_W  host operand A
i_req_b  in  DATA_W  host operand B
i_alu_busy  in  1  ALU busy (registered in ALU)
o_alu_valid  out  1  issue strobe to ALU i_in_valid
o_alu_inst  out  INST_W  issued opcode
o_alu_a  out  DATA_W  issued operand A
o_alu_b  out  DATA_W  issued operand B
o_count  out  AW+1  current FIFO occupancy
o_group_active  out  1  high in GROUP and DRAIN states

Behaviour:
- Reset (async): FIFO pointers 0; count 0; state IDLE; o_alu_valid 0; o_alu_inst/a/b 0; o_group_active 0; o_req_ready 1 (derived from count).
- Push: occurs on an edge where i_req_valid && o_req_ready. o_req_ready is derived from registered count only; there is no push-through-full, even when a pop happens in the same cycle.
- Simultaneous push and pop: count unchanged. Pointers wrap modulo DEPTH.
- Issue outputs are registered. A pop at edge t sets o_alu_valid=1 with the head fields for exactly one cycle. Otherwise o_alu_valid=0, and inst/a/b hold their last values.
- Minimum latency is 1 cycle: an entry pushed at edge t can be issued at edge t+1.
- State IDLE:
  - count==0 or i_alu_busy: no issue.
  - Head opcode == MAT_INST: if count >= MAT_LEN, go to GROUP with row counter 0 and do not pop this cycle; otherwise wait.
  - Head opcode == MAC_INST: pop and go to GAP.
  - Any other opcode: pop and stay in IDLE.
- State GAP: exactly 1 cycle with no issue, covering the ALU's 1-cycle busy reporting delay. Then go to IDLE.
- State GROUP:
  - Pops MAT_LEN entries on consecutive edges, ignoring i_alu_busy.
  - Opcodes are not checked; the host guarantees MAT_LEN consecutive MAT_INST entries.
  - After the pop with row counter == MAT_LEN-1, go to DRAIN.
- State DRAIN:
  - No issue.
  - Wait until i_alu_busy has been sampled high at least once, then sampled low. Then go to IDLE.
  - Guard: after 2*MAT_LEN+4 cycles without seeing busy high, return to IDLE.
- Pushes are accepted in every state.
- o_count updates every edge.
- Reset mid-operation (any state, including mid-GROUP) discards all queued entries and returns to reset values. No partial group resumes.

Test Plan:
1. After reset, push ADD(0000, a=0x0400, b=0x0800) with busy=0 -> o_alu_valid pulses 1 cycle on the edge after the push with inst=0, a=0x0400, b=0x0800; o_count returns to 0.
2. Push MAC, then SUB back-to-back, busy=0 -> MAC issued at edge t, no issue at t+1 (GAP), SUB at t+2.
3. Push 5 ADDs while busy=1 for 6 cycles -> no issue while busy; after busy drops, 5 consecutive valid cycles in FIFO order; o_count goes 5->0.
4. Push 7 MAT_INST rows -> no issue, o_group_active=0. Push the 8th -> o_group_active rises, 8 consecutive valid cycles with rows in order even if busy=1 during them. Model busy high for 8 cycles then low -> next queued ADD issues only after busy falls.
5. Fill 16 entries with busy=1 -> o_req_ready=0 at count 16, and a 17th request is held unaccepted. One pop -> ready=1; the held request is accepted; wrap-around order is preserved.
6. Assert reset during GROUP after row 3 -> o_alu_valid=0, o_count=0, o_group_active=0 immediately. After release, a new ADD issues normally.
